// File: rtl/cpu_status_pkg.sv
// Shared status codes and test FSM encoding for the CPU status pad driver.
// The CPU top and the firmware test headers rely on these same values.
package cpu_status_pkg;

    localparam logic [5:0] STATUS_IDLE = 6'h00;
    localparam logic [5:0] STATUS_RUN  = 6'h18;
    localparam logic [5:0] STATUS_PASS = 6'h19;
    localparam logic [5:0] STATUS_FAIL = 6'h1a;

    typedef enum logic [2:0] {
        ST_DELAY      = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } test_state_e;

endpackage

// File: rtl/cpu_status_io_if.sv
// CPU event inputs and pad-side outputs of the status driver.
// master = CPU core / pad side, slave = cpu_status_io.
interface cpu_status_io_if;

    logic        cpu_start;
    logic        pc_valid;
    logic [31:0] pc;
    logic        cpu_done;
    logic        cpu_fail;
    logic [31:0] event_pc;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [2:0]  test_state;

    modport master (
        output cpu_start, pc_valid, pc, cpu_done, cpu_fail, event_pc,
        input  io_out, io_oeb, test_state
    );

    modport slave (
        input  cpu_start, pc_valid, pc, cpu_done, cpu_fail, event_pc,
        output io_out, io_oeb, test_state
    );

endinterface

// File: rtl/cpu_status_io_wdog.sv
// Saturating 32-bit up-counter with synchronous clear, count enable and a
// terminal-count flag. Serves as both the startup delay and the watchdog.
module status_wdog #(
    parameter logic [31:0] TC_VALUE = 32'd0
) (
    input  logic clock,
    input  logic resetb,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [31:0] r_count;
    logic        w_atTc;

    assign w_atTc = (r_count == TC_VALUE);
    assign o_tc   = w_atTc;

    // Count while enabled, stop at the terminal value, restart on clear.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_count <= 32'd0;
        end else if (i_clear) begin
            r_count <= 32'd0;
        end else if (i_enable && !w_atTc) begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/cpu_status_io.sv
// Drives CPU test status (io_out[37:32]) and pc (io_out[31:0]) onto the
// user-project pads. Pads stay tristated until the startup delay expires so
// the management core can configure the GPIOs first.
module cpu_status_io
    import cpu_status_pkg::*;
#(
    parameter int unsigned  STARTUP_DELAY = 2048,
    parameter int unsigned  WDOG_CYCLES   = 65536,
    parameter logic [37:0]  OEB_MASK      = 38'h9
) (
    input  logic             clock,
    input  logic             resetb,
    cpu_status_io_if.slave   bus
);

    localparam logic [31:0] DELAY_TC = (STARTUP_DELAY > 0) ? 32'(STARTUP_DELAY - 1) : 32'd0;
    localparam logic [31:0] WDOG_TC  = (WDOG_CYCLES > 0)   ? 32'(WDOG_CYCLES - 1)   : 32'd0;
    localparam logic        WDOG_EN  = (WDOG_CYCLES != 0);

    test_state_e r_state;
    logic [5:0]  r_status;
    logic [31:0] r_pcField;
    logic [37:0] r_oeb;
    logic        r_startPending;

    logic w_inDelay;
    logic w_inRun;
    logic w_delayTc;
    logic w_wdogTc;
    logic w_wdogFire;

    assign w_inDelay  = (r_state == ST_DELAY);
    assign w_inRun    = (r_state == ST_RUN);
    assign w_wdogFire = WDOG_EN && w_inRun && w_wdogTc && !bus.pc_valid;

    assign bus.io_out     = {r_status, r_pcField};
    assign bus.io_oeb     = r_oeb;
    assign bus.test_state = r_state;

    status_wdog #(.TC_VALUE(DELAY_TC)) u_delay (
        .clock    (clock),
        .resetb   (resetb),
        .i_clear  (!w_inDelay),
        .i_enable (w_inDelay),
        .o_tc     (w_delayTc)
    );

    // A retire restarts the watchdog; outside RUN it is held at zero.
    status_wdog #(.TC_VALUE(WDOG_TC)) u_wdog (
        .clock    (clock),
        .resetb   (resetb),
        .i_clear  (!w_inRun || bus.pc_valid),
        .i_enable (w_inRun),
        .o_tc     (w_wdogTc)
    );

    // Test FSM; status and pc field change on the same edge so a monitor
    // triggering on the status always sees the matching pc.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state        <= ST_DELAY;
            r_status       <= STATUS_IDLE;
            r_pcField      <= 32'd0;
            r_oeb          <= '1;
            r_startPending <= 1'b0;
        end else begin
            case (r_state)
                ST_DELAY: begin
                    if (bus.cpu_start) begin
                        r_startPending <= 1'b1;
                    end
                    if (w_delayTc) begin
                        r_oeb          <= OEB_MASK;
                        r_startPending <= 1'b0;
                        if (r_startPending || bus.cpu_start) begin
                            r_state  <= ST_RUN;
                            r_status <= STATUS_RUN;
                        end else begin
                            r_state  <= ST_WAIT_START;
                        end
                    end
                end
                ST_WAIT_START: begin
                    if (bus.cpu_fail) begin
                        r_state   <= ST_FAIL;
                        r_status  <= STATUS_FAIL;
                        r_pcField <= bus.event_pc;
                    end else if (bus.cpu_start) begin
                        r_state  <= ST_RUN;
                        r_status <= STATUS_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.cpu_fail) begin
                        r_state   <= ST_FAIL;
                        r_status  <= STATUS_FAIL;
                        r_pcField <= bus.event_pc;
                    end else if (bus.cpu_done) begin
                        r_state   <= ST_PASS;
                        r_status  <= STATUS_PASS;
                        r_pcField <= bus.event_pc;
                    end else if (w_wdogFire) begin
                        r_state  <= ST_FAIL;
                        r_status <= STATUS_FAIL;
                    end else if (bus.pc_valid) begin
                        r_pcField <= bus.pc;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_DELAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_status_io.sv
// Directed self-checking bench for cpu_status_io with a short startup delay
// and watchdog so every scenario fits in a few hundred cycles.
module tb_cpu_status_io;
    import cpu_status_pkg::*;

    localparam logic [37:0] MASK    = 38'h9;
    localparam logic [63:0] ALL_OEB = 64'h3f_ffff_ffff;

    logic clock;
    logic resetb;
    int   errCount;
    int   checkCount;

    cpu_status_io_if busIf ();

    cpu_status_io #(
        .STARTUP_DELAY (16),
        .WDOG_CYCLES   (64),
        .OEB_MASK      (MASK)
    ) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (busIf)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [63:0] padWord(input logic [5:0] status, input logic [31:0] pcVal);
        padWord = 64'({status, pcVal});
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge consume them, sample #1 later.
    task automatic applyStimulus(input logic start, input logic valid, input logic [31:0] pcVal,
                                 input logic done, input logic fail, input logic [31:0] evPc);
        busIf.cpu_start = start;
        busIf.pc_valid  = valid;
        busIf.pc        = pcVal;
        busIf.cpu_done  = done;
        busIf.cpu_fail  = fail;
        busIf.event_pc  = evPc;
        @(posedge clock);
        #1;
        busIf.cpu_start = 1'b0;
        busIf.pc_valid  = 1'b0;
        busIf.cpu_done  = 1'b0;
        busIf.cpu_fail  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'd0, 0, 0, 32'd0);
    endtask

    // Asynchronous reset pulse; reset values must appear without a clock edge.
    task automatic doReset(input string tag);
        resetb = 1'b0;
        #1;
        checkOutput({tag, "_rst_out"},   64'(busIf.io_out), 64'd0);
        checkOutput({tag, "_rst_oeb"},   64'(busIf.io_oeb), ALL_OEB);
        checkOutput({tag, "_rst_state"}, 64'(busIf.test_state), 64'(ST_DELAY));
        @(posedge clock);
        #1;
        resetb = 1'b1;
    endtask

    // Reset, let the delay expire with no start, then start from WAIT_START.
    task automatic startRun(input string tag);
        doReset(tag);
        idle(16);
        checkOutput({tag, "_wait_state"}, 64'(busIf.test_state), 64'(ST_WAIT_START));
        applyStimulus(0, 0, 32'd0, 1, 0, 32'h55);
        checkOutput({tag, "_done_ignored"}, 64'(busIf.test_state), 64'(ST_WAIT_START));
        checkOutput({tag, "_done_ign_out"}, 64'(busIf.io_out), 64'd0);
        applyStimulus(1, 0, 32'd0, 0, 0, 32'd0);
        checkOutput({tag, "_run_state"}, 64'(busIf.test_state), 64'(ST_RUN));
        checkOutput({tag, "_run_out"},   64'(busIf.io_out), padWord(STATUS_RUN, 32'd0));
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        resetb     = 1'b1;
        busIf.cpu_start = 1'b0;
        busIf.pc_valid  = 1'b0;
        busIf.pc        = 32'd0;
        busIf.cpu_done  = 1'b0;
        busIf.cpu_fail  = 1'b0;
        busIf.event_pc  = 32'd0;
        #2;

        // 1: no events; pads tristated through cycle 15, masked from 16.
        $display("[TB] test 1: reset, no events");
        doReset("t1");
        for (int k = 0; k < 16; k++) begin
            checkOutput("t1_oeb_delay", 64'(busIf.io_oeb), ALL_OEB);
            checkOutput("t1_status_delay", 64'(busIf.io_out), 64'd0);
            idle(1);
        end
        checkOutput("t1_oeb_mask", 64'(busIf.io_oeb), 64'(MASK));
        checkOutput("t1_state_wait", 64'(busIf.test_state), 64'(ST_WAIT_START));
        idle(20);
        checkOutput("t1_oeb_hold", 64'(busIf.io_oeb), 64'(MASK));
        checkOutput("t1_still_wait", 64'(busIf.test_state), 64'(ST_WAIT_START));
        checkOutput("t1_status_idle", 64'(busIf.io_out), 64'd0);

        // 2: cpu_start in cycle 5 is remembered until expiry.
        $display("[TB] test 2: start during delay");
        doReset("t2");
        idle(5);
        applyStimulus(1, 0, 32'd0, 0, 0, 32'd0);
        idle(9);
        checkOutput("t2_cycle15_state", 64'(busIf.test_state), 64'(ST_DELAY));
        checkOutput("t2_cycle15_out", 64'(busIf.io_out), 64'd0);
        idle(1);
        checkOutput("t2_run_state", 64'(busIf.test_state), 64'(ST_RUN));
        checkOutput("t2_run_out", 64'(busIf.io_out), padWord(STATUS_RUN, 32'd0));
        checkOutput("t2_run_oeb", 64'(busIf.io_oeb), 64'(MASK));

        // 3: retires tracked, then done with event_pc; PASS is sticky.
        $display("[TB] test 3: retires then done");
        applyStimulus(0, 1, 32'h100, 0, 0, 32'd0);
        checkOutput("t3_pc100", 64'(busIf.io_out), padWord(STATUS_RUN, 32'h100));
        applyStimulus(0, 1, 32'h104, 0, 0, 32'd0);
        checkOutput("t3_pc104", 64'(busIf.io_out), padWord(STATUS_RUN, 32'h104));
        applyStimulus(0, 1, 32'h108, 0, 0, 32'd0);
        checkOutput("t3_pc108", 64'(busIf.io_out), padWord(STATUS_RUN, 32'h108));
        applyStimulus(0, 0, 32'd0, 1, 0, 32'h200);
        checkOutput("t3_pass", 64'(busIf.io_out), padWord(STATUS_PASS, 32'h200));
        checkOutput("t3_pass_state", 64'(busIf.test_state), 64'(ST_PASS));
        applyStimulus(1, 1, 32'h400, 0, 1, 32'h404);
        checkOutput("t3_pass_sticky", 64'(busIf.io_out), padWord(STATUS_PASS, 32'h200));

        // 4: fail wins over done; FAIL ignores later events.
        $display("[TB] test 4: done and fail together");
        startRun("t4");
        applyStimulus(0, 0, 32'd0, 1, 1, 32'h3c);
        checkOutput("t4_fail", 64'(busIf.io_out), padWord(STATUS_FAIL, 32'h3c));
        checkOutput("t4_fail_state", 64'(busIf.test_state), 64'(ST_FAIL));
        applyStimulus(1, 0, 32'd0, 0, 0, 32'd0);
        checkOutput("t4_after_start", 64'(busIf.io_out), padWord(STATUS_FAIL, 32'h3c));
        applyStimulus(0, 1, 32'h70, 1, 0, 32'h74);
        checkOutput("t4_after_done", 64'(busIf.io_out), padWord(STATUS_FAIL, 32'h3c));

        // 5a: 64 cycles without a retire trip the watchdog.
        $display("[TB] test 5: watchdog");
        startRun("t5a");
        applyStimulus(0, 1, 32'h44, 0, 0, 32'd0);
        idle(63);
        checkOutput("t5a_run_63", 64'(busIf.test_state), 64'(ST_RUN));
        idle(1);
        checkOutput("t5a_wdog_fail", 64'(busIf.io_out), padWord(STATUS_FAIL, 32'h44));
        checkOutput("t5a_wdog_state", 64'(busIf.test_state), 64'(ST_FAIL));

        // 5b: a retire on idle cycle 62 restarts the count.
        startRun("t5b");
        applyStimulus(0, 1, 32'h44, 0, 0, 32'd0);
        idle(61);
        applyStimulus(0, 1, 32'h48, 0, 0, 32'd0);
        idle(63);
        checkOutput("t5b_no_fail", 64'(busIf.io_out), padWord(STATUS_RUN, 32'h48));
        idle(1);
        checkOutput("t5b_late_fail", 64'(busIf.io_out), padWord(STATUS_FAIL, 32'h48));

        // 6: reset mid-RUN, then a full pending-start sequence to PASS.
        $display("[TB] test 6: reset mid-run");
        startRun("t6a");
        applyStimulus(0, 1, 32'h80, 0, 0, 32'd0);
        checkOutput("t6_pc80", 64'(busIf.io_out), padWord(STATUS_RUN, 32'h80));
        doReset("t6");
        idle(3);
        applyStimulus(1, 0, 32'd0, 0, 0, 32'd0);
        idle(11);
        checkOutput("t6_delay15", 64'(busIf.test_state), 64'(ST_DELAY));
        idle(1);
        checkOutput("t6_run", 64'(busIf.io_out), padWord(STATUS_RUN, 32'd0));
        checkOutput("t6_oeb", 64'(busIf.io_oeb), 64'(MASK));
        applyStimulus(0, 1, 32'h300, 1, 0, 32'h304);
        checkOutput("t6_pass_evpc", 64'(busIf.io_out), padWord(STATUS_PASS, 32'h304));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
